// File: rtl/lfsr_sync_checker.sv
// Receive-side keystream checker: seeds a predictor from incoming LFSR words,
// locks after a run of correct words, then freewheels and counts mismatches.
module lfsr_sync_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int TP1        = 0,
  parameter int TP2        = 2,
  parameter int TP3        = 3,
  parameter int TP4        = 4,
  parameter int TP5        = 7,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_THR = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  input  logic                  err_clr,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      err_count
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(UNLOCK_THR + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pred_q, pred_d;
  logic [MC_W-1:0]       match_cnt_q, match_cnt_d, match_inc;
  logic [MS_W-1:0]       miss_cnt_q, miss_cnt_d, miss_inc;
  logic [CNT_W-1:0]      err_count_q, err_count_d;
  logic                  locked_q;
  logic                  err_pulse_q;
  logic                  err_hit;
  logic                  data_match;

  // Single generator step; must stay bit-identical to the transmit side.
  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] s);
    return {s[DATA_WIDTH-2:0], s[TP5] ^ s[TP4] ^ s[TP3] ^ s[TP2] ^ s[TP1]};
  endfunction

  assign data_match = (data_in == pred_q);
  assign match_inc  = match_cnt_q + MC_W'(1);
  assign miss_inc   = miss_cnt_q + MS_W'(1);

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_hit     = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (data_in != '0) begin
            pred_d      = lfsr_next(data_in);
            match_cnt_d = '0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (data_match) begin
            pred_d      = lfsr_next(data_in);
            match_cnt_d = match_inc;
            if (match_inc == MC_W'(LOCK_CNT)) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end else if (data_in == '0) begin
            // An all-zero word cannot seed, so fall back and wait for a real one.
            match_cnt_d = '0;
            state_d     = ST_SEARCH;
          end else begin
            pred_d      = lfsr_next(data_in);
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          pred_d = lfsr_next(pred_q);
          if (data_match) begin
            miss_cnt_d = '0;
          end else begin
            err_hit    = 1'b1;
            miss_cnt_d = miss_inc;
            if (miss_inc == MS_W'(UNLOCK_THR)) begin
              state_d = ST_SEARCH;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; the counter sticks at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (err_hit && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_SEARCH;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      locked_q    <= (state_d == ST_LOCKED);
      err_pulse_q <= err_hit;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// Bench for lfsr_sync_checker: directed scenarios plus randomized keystream with
// corruption, gaps, zeros, clears and resets, checked against a behavioural model.
module tb_lfsr_sync_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       vld;
  logic       clr;
  logic       lk_a, ep_a, lk_b, ep_b;
  logic [15:0] ec_a;
  logic [1:0]  ec_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_sync_checker dut_a (
    .clk(clk), .rst(rst_n), .data_in(din), .in_valid(vld), .err_clr(clr),
    .locked(lk_a), .err_pulse(ep_a), .err_count(ec_a)
  );

  lfsr_sync_checker #(.UNLOCK_THR(15), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_n), .data_in(din), .in_valid(vld), .err_clr(clr),
    .locked(lk_b), .err_pulse(ep_b), .err_count(ec_b)
  );

  // Model: mode 0 = hunting for a seed, 1 = confirming, 2 = freewheeling.
  typedef struct {
    int mode;
    int pred;
    int mcnt;
    int miss;
    int lk;
    int pulse;
    int errc;
  } mdl_t;

  mdl_t ma, mb;

  // Generator step: shift left, feed back parity of tapped bits {7,4,3,2,0}.
  function automatic int nxt(input int s);
    return ((s << 1) & 8'hFF) | ($countones(s & 8'h9D) & 1);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int lockc, input int unl,
                                    input int maxc, input bit rstn, input bit v,
                                    input int d, input bit c);
    mdl_t r;
    bit   inc;
    r = m;
    inc = 1'b0;
    if (!rstn) begin
      r = '{mode: 0, pred: 0, mcnt: 0, miss: 0, lk: 0, pulse: 0, errc: 0};
      return r;
    end
    r.pulse = 0;
    if (v) begin
      if (r.mode == 0) begin
        if (d != 0) begin
          r.pred = nxt(d); r.mcnt = 0; r.mode = 1;
        end
      end else if (r.mode == 1) begin
        if (d == r.pred) begin
          r.pred = nxt(d); r.mcnt++;
          if (r.mcnt == lockc) begin r.mode = 2; r.miss = 0; end
        end else if (d == 0) begin
          r.mode = 0; r.mcnt = 0;
        end else begin
          r.pred = nxt(d); r.mcnt = 0;
        end
      end else begin
        if (d == r.pred) r.miss = 0;
        else begin
          r.pulse = 1; inc = 1'b1; r.miss++;
          if (r.miss == unl) r.mode = 0;
        end
        r.pred = nxt(r.pred);
      end
    end
    r.lk = (r.mode == 2) ? 1 : 0;
    if (c) r.errc = 0;
    else if (inc && r.errc < maxc) r.errc++;
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rstn, input bit v, input int d, input bit c);
    rst_n = rstn; vld = v; din = 8'(d); clr = c;
    @(posedge clk);
    ma = mdl_step(ma, 4, 3, 65535, rstn, v, d, c);
    mb = mdl_step(mb, 4, 15, 3, rstn, v, d, c);
    #1;
    $display("txn t=%0t rst=%0b v=%0b d=%02h clr=%0b | A lk=%0b ep=%0b ec=%0d | B lk=%0b ep=%0b ec=%0d",
             $time, rstn, v, d & 8'hFF, c, lk_a, ep_a, ec_a, lk_b, ep_b, ec_b);
    check("lock_a", int'(lk_a), ma.lk);
    check("pulse_a", int'(ep_a), ma.pulse);
    check("count_a", int'(ec_a), ma.errc);
    check("lock_b", int'(lk_b), mb.lk);
    check("pulse_b", int'(ep_b), mb.pulse);
    check("count_b", int'(ec_b), mb.errc);
  endtask

  task automatic lock_seq();
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h03, 0);
    step(1, 1, 8'h07, 0);
    step(1, 1, 8'h0E, 0);
    check("t2_prelock", int'(lk_a), 0);
    step(1, 1, 8'h1C, 0);
    check("t2_locked", int'(lk_a), 1);
  endtask

  initial begin
    int g;
    int d;
    bit v, rs, c;
    ma = '{mode: 0, pred: 0, mcnt: 0, miss: 0, lk: 0, pulse: 0, errc: 0};
    mb = ma;
    rst_n = 1'b0; vld = 1'b0; din = '0; clr = 1'b0;

    // T1: reset while valid traffic is present
    step(0, 1, 8'h55, 0);
    step(0, 1, 8'h55, 0);
    check("t1_locked", int'(lk_a), 0);
    check("t1_pulse", int'(ep_a), 0);
    check("t1_count", int'(ec_a), 0);

    // T2 / T3: lock, then one bad word in the freewheeling stream
    lock_seq();
    check("t2_count", int'(ec_a), 0);
    step(1, 1, 8'h39, 0);
    step(1, 1, 8'h72, 0);
    check("t3_pulse", int'(ep_a), 1);
    check("t3_count", int'(ec_a), 1);
    step(1, 1, 8'hE6, 0);
    check("t3_pulse_gone", int'(ep_a), 0);
    check("t3_still_lock", int'(lk_a), 1);
    check("t3_count_hold", int'(ec_a), 1);

    // T4: three consecutive misses drop lock
    step(1, 0, 8'h00, 1);
    step(1, 1, 8'hAA, 0);
    step(1, 1, 8'hAA, 0);
    check("t4_lock_mid", int'(lk_a), 1);
    step(1, 1, 8'hAA, 0);
    check("t4_count", int'(ec_a), 3);
    check("t4_pulse", int'(ep_a), 1);
    check("t4_unlocked", int'(lk_a), 0);

    // T5: zero ignored in search, gap in verify
    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h03, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'hFF, 0);
    check("t5_gap_nolock", int'(lk_a), 0);
    step(1, 1, 8'h07, 0);
    step(1, 1, 8'h0E, 0);
    check("t5_prelock", int'(lk_a), 0);
    step(1, 1, 8'h1C, 0);
    check("t5_locked", int'(lk_a), 1);

    // T6: narrow counter saturates; clear beats a same-cycle error
    step(0, 0, 8'h00, 0);
    lock_seq();
    for (int i = 0; i < 5; i++) step(1, 1, 8'hAA, 0);
    check("t6_sat", int'(ec_b), 3);
    check("t6_lock_b", int'(lk_b), 1);
    step(1, 1, 8'hAA, 1);
    check("t6_clr_count", int'(ec_b), 0);
    check("t6_clr_pulse", int'(ep_b), 1);

    // Randomized keystream with faults
    g = $urandom_range(1, 255);
    for (int i = 0; i < 2000; i++) begin
      rs = ($urandom_range(0, 999) >= 4);
      v  = ($urandom_range(0, 99) < 85);
      c  = ($urandom_range(0, 99) < 2);
      d  = $urandom_range(0, 255);
      if (v) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2) begin
          g = $urandom_range(1, 255);
        end
        d = g;
        g = nxt(g);
        if (r >= 2 && r < 6) d = d ^ $urandom_range(1, 255);
        else if (r >= 6 && r < 8) d = 0;
      end
      step(rs, v, d, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
